rt_lim_readback: RTL and testbench

Port-B readback engine for the LiM racetrack data memory (`dp_ram`). It is the read-side counterpart of the word-by-word port-B initialization sequence.
- For each word, it pulses the port-B request, waits for the racetrack read-valid pulse and captures the read data.
- Each captured word is presented on a valid/ready stream, together with its byte address.
- It sits beside the core in `riscv_wrapper`. It is used for memory dump, load verification and result extraction after LiM kernels, and it never issues LiM operations.

---
 rtl/rt_lim_readback.sv | 178 +++++++++++++++++
 tb/tb_rt_lim_readback.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rt_lim_readback.sv
// Port-B readback engine for the LiM racetrack data memory: reads a burst of words
// one at a time and presents each captured word with its byte address on a valid/ready stream.
module rt_lim_readback #(
  parameter int unsigned ADDR_WIDTH = 22,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [CNT_WIDTH-1:0]  num_words_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic                  en_b_o,
  output logic                  we_b_o,
  output logic [3:0]            be_b_o,
  output logic [ADDR_WIDTH-1:0] addr_b_o,
  output logic [2:0]            lim_funct_o,
  output logic                  we_funct_o,
  output logic [ADDR_WIDTH-1:0] addr_range_o,
  input  logic                  rvalid_b_i,
  input  logic [31:0]           rdata_b_i,
  output logic [31:0]           data_o,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int unsigned         TO_W      = $clog2(TIMEOUT);
  localparam logic [TO_W-1:0]     TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_GAP  = 3'd3,
    S_OUT  = 3'd4,
    S_DONE = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  rvalid_prev_q;
  logic [31:0]           data_q, data_d;
  logic [ADDR_WIDTH-1:0] data_addr_q, data_addr_d;
  logic                  error_q, error_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  en_q, en_d;
  logic                  valid_q, valid_d;
  logic                  rv_rise_s;

  // Only a fresh rising edge counts, so a level held high across a request is not re-read.
  assign rv_rise_s = rvalid_b_i & ~rvalid_prev_q;

  // Next-state, datapath and decoded-output logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    to_cnt_d    = to_cnt_q;
    data_d      = data_q;
    data_addr_d = data_addr_q;
    error_d     = error_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d  = base_addr_i & WORD_MASK;
          rem_d   = num_words_i;
          error_d = 1'b0;
          if (num_words_i == {CNT_WIDTH{1'b0}}) begin
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        to_cnt_d = {TO_W{1'b0}};
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (rv_rise_s) begin
          data_d      = rdata_b_i;
          data_addr_d = addr_q;
          state_d     = S_GAP;
        end else if (to_cnt_q == TO_LAST) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_GAP: begin
        state_d = S_OUT;
      end
      S_OUT: begin
        if (ready_i) begin
          addr_d = addr_q + ADDR_WIDTH'(4);
          rem_d  = rem_q - CNT_WIDTH'(1);
          if (rem_q == CNT_WIDTH'(1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end else begin
          state_d = S_OUT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered from the upcoming state so they align with it.
    en_d    = (state_d == S_REQ);
    valid_d = (state_d == S_OUT);
    done_d  = (state_d == S_DONE);
    busy_d  = (state_d == S_REQ) || (state_d == S_WAIT) ||
              (state_d == S_GAP) || (state_d == S_OUT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      addr_q        <= {ADDR_WIDTH{1'b0}};
      rem_q         <= {CNT_WIDTH{1'b0}};
      to_cnt_q      <= {TO_W{1'b0}};
      rvalid_prev_q <= 1'b0;
      data_q        <= 32'h0000_0000;
      data_addr_q   <= {ADDR_WIDTH{1'b0}};
      error_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      en_q          <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rem_q         <= rem_d;
      to_cnt_q      <= to_cnt_d;
      rvalid_prev_q <= rvalid_b_i;
      data_q        <= data_d;
      data_addr_q   <= data_addr_d;
      error_q       <= error_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      en_q          <= en_d;
      valid_q       <= valid_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign en_b_o       = en_q;
  assign we_b_o       = 1'b0;
  assign be_b_o       = 4'b1111;
  assign addr_b_o     = addr_q;
  assign lim_funct_o  = 3'b000;
  assign we_funct_o   = 1'b0;
  assign addr_range_o = {ADDR_WIDTH{1'b0}};
  assign data_o       = data_q;
  assign data_addr_o  = data_addr_q;
  assign valid_o      = valid_q;

endmodule

// File: tb/tb_rt_lim_readback.sv
// Randomized bench for rt_lim_readback: a racetrack memory responder plus an expected-beat
// queue built from burst parameters, checked by one per-cycle compare process.
module tb_rt_lim_readback;

  localparam int AW = 22;
  localparam int CW = 16;
  localparam int TO = 64;

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [CW-1:0] num_words_i;
  logic          busy_o, done_o, error_o, en_b_o, we_b_o, we_funct_o, valid_o;
  logic [3:0]    be_b_o;
  logic [2:0]    lim_funct_o;
  logic [AW-1:0] addr_b_o, addr_range_o, data_addr_o;
  logic          rvalid_b_i, ready_i;
  logic [31:0]   rdata_b_i, data_o;

  rt_lim_readback #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
    .num_words_i(num_words_i), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .en_b_o(en_b_o), .we_b_o(we_b_o), .be_b_o(be_b_o), .addr_b_o(addr_b_o),
    .lim_funct_o(lim_funct_o), .we_funct_o(we_funct_o), .addr_range_o(addr_range_o),
    .rvalid_b_i(rvalid_b_i), .rdata_b_i(rdata_b_i), .data_o(data_o),
    .data_addr_o(data_addr_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0]   mem [256];
  logic [AW-1:0] exp_addr_q[$];
  logic [31:0]   exp_data_q[$];
  logic [AW-1:0] log_addr [16];
  logic [31:0]   log_data [16];

  int en_cnt = 0, done_cnt = 0, beats_seen = 0;
  int cyc = 0, last_en_cyc = -100, done_cyc = 0;
  int suppress_idx = 1000;
  bit rand_ready = 1'b0;
  bit hold_mode = 1'b0;
  int hold_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Racetrack responder and stream-ready driver.
  initial begin : responder
    int countdown;
    int hi_left;
    logic [AW-1:0] lat_addr;
    countdown = 0; hi_left = 0; lat_addr = '0;
    rvalid_b_i = 1'b0; rdata_b_i = 32'h0; ready_i = 1'b1;
    forever begin
      @(negedge clk);
      if (hold_mode && beats_seen == 1 && valid_o && hold_cnt < 10) begin
        ready_i = 1'b0;
        hold_cnt++;
      end else if (rand_ready) begin
        ready_i = ($urandom_range(0, 3) != 0);
      end else begin
        ready_i = 1'b1;
      end
      if (!rst_n) begin
        countdown = 0; hi_left = 0; rvalid_b_i = 1'b0;
      end else begin
        if (hi_left > 0) begin
          hi_left--;
          if (hi_left == 0) rvalid_b_i = 1'b0;
        end
        if (countdown > 0) begin
          countdown--;
          if (countdown == 0) begin
            rvalid_b_i = 1'b1;
            rdata_b_i  = mem[lat_addr[9:2]];
            hi_left    = $urandom_range(1, 2);
          end
        end
        if (en_b_o) begin
          lat_addr = addr_b_o;
          if (en_cnt != suppress_idx) countdown = $urandom_range(1, 4);
        end
      end
    end
  end

  // Per-cycle compare process against the expected-beat queue.
  initial begin : checker_p
    bit prev_hold;
    logic [31:0] prev_data;
    logic [AW-1:0] prev_addr;
    logic [AW-1:0] ea;
    logic [31:0] ed;
    prev_hold = 1'b0; prev_data = '0; prev_addr = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        chk("port_b_constants", 64'({we_b_o, be_b_o, lim_funct_o, we_funct_o, addr_range_o}),
            64'({1'b0, 4'hF, 3'b000, 1'b0, {AW{1'b0}}}));
        if (prev_hold) begin
          chk("hold_valid", 64'(valid_o), 64'(1));
          chk("hold_data", 64'(data_o), 64'(prev_data));
          chk("hold_addr", 64'(data_addr_o), 64'(prev_addr));
        end
        if (done_o) begin
          done_cnt++;
          done_cyc = cyc;
          chk("busy_low_at_done", 64'(busy_o), 64'(0));
        end
        if (en_b_o) begin
          chk("en_gap_ge3", 64'((cyc - last_en_cyc) >= 4), 64'(1));
          en_cnt++;
          last_en_cyc = cyc;
        end
        if (valid_o && ready_i) begin
          if (exp_addr_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL beat_unexpected: got addr %0h data %0h, expected no beat", data_addr_o, data_o);
          end else begin
            ea = exp_addr_q.pop_front();
            ed = exp_data_q.pop_front();
            chk("beat_addr", 64'(data_addr_o), 64'(ea));
            chk("beat_data", 64'(data_o), 64'(ed));
          end
          if (beats_seen < 16) begin
            log_addr[beats_seen] = data_addr_o;
            log_data[beats_seen] = data_o;
          end
          beats_seen++;
        end
        prev_hold = valid_o && !ready_i;
        prev_data = data_o;
        prev_addr = data_addr_o;
      end
    end
  end

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done_o !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_reached", 64'(done_o), 64'(1));
  endtask

  task automatic run_burst(input logic [AW-1:0] base, input int n, input int sup,
                           input bit hold, input bit stray);
    int exp_beats, exp_en;
    logic [AW-1:0] a;
    exp_beats = (sup < n) ? sup : n;
    exp_en    = (n == 0) ? 0 : ((sup < n) ? sup + 1 : n);
    @(negedge clk);
    a = base & ~AW'(3);
    for (int i = 0; i < exp_beats; i++) begin
      exp_addr_q.push_back(a);
      exp_data_q.push_back(mem[a[9:2]]);
      a = a + AW'(4);
    end
    en_cnt = 0; done_cnt = 0; beats_seen = 0; hold_cnt = 0;
    suppress_idx = sup; hold_mode = hold;
    start_i = 1'b1; base_addr_i = base; num_words_i = CW'(n);
    @(negedge clk);
    start_i = 1'b0;
    chk("busy_after_start", 64'(busy_o), 64'(n != 0));
    chk("en_after_start", 64'(en_b_o), 64'(n != 0));
    chk("done_after_start", 64'(done_o), 64'(n == 0));
    chk("error_cleared_by_start", 64'(error_o), 64'(0));
    if (stray) begin
      @(negedge clk);
      start_i = 1'b1; base_addr_i = AW'(32'h40); num_words_i = CW'(1);
      @(negedge clk);
      start_i = 1'b0;
    end
    wait_done(3000);
    @(negedge clk);
    chk("done_one_cycle", 64'(done_o), 64'(0));
    chk("busy_idle", 64'(busy_o), 64'(0));
    chk("valid_idle", 64'(valid_o), 64'(0));
    chk("done_count", 64'(done_cnt), 64'(1));
    chk("en_pulse_count", 64'(en_cnt), 64'(exp_en));
    chk("beat_count", 64'(beats_seen), 64'(exp_beats));
    chk("queue_drained", 64'(exp_addr_q.size()), 64'(0));
    chk("error_flag", 64'(error_o), 64'(sup < n));
    hold_mode = 1'b0;
    suppress_idx = 1000;
    repeat (2) @(negedge clk);
  endtask

  initial begin : main
    int n, sup;
    logic [AW-1:0] b;
    rst_n = 1'b0; start_i = 1'b0; base_addr_i = '0; num_words_i = '0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom();
    mem[0] = 32'h0000_0013; mem[1] = 32'hDEAD_BEEF; mem[2] = 32'h1234_5678;
    repeat (3) @(negedge clk);
    chk("reset_status", 64'({busy_o, done_o, error_o, en_b_o, valid_o}), 64'(0));
    chk("reset_data", 64'(data_o), 64'(0));
    chk("reset_addrs", 64'({data_addr_o, addr_b_o}), 64'(0));
    rst_n = 1'b1;

    // Directed: three-word dump with known contents
    rand_ready = 1'b0;
    run_burst(AW'(0), 3, 1000, 1'b0, 1'b0);
    chk("t1_data0", 64'(log_data[0]), 64'(32'h0000_0013));
    chk("t1_data1", 64'(log_data[1]), 64'(32'hDEAD_BEEF));
    chk("t1_data2", 64'(log_data[2]), 64'(32'h1234_5678));
    chk("t1_addrs", 64'({log_addr[0], log_addr[1], log_addr[2]}),
        64'({22'h000000, 22'h000004, 22'h000008}));

    // Address wrap at the top of the space
    run_burst(AW'(32'h3FFFFC), 2, 1000, 1'b0, 1'b0);
    chk("t2_addr0", 64'(log_addr[0]), 64'(22'h3FFFFC));
    chk("t2_addr1", 64'(log_addr[1]), 64'(22'h000000));

    // Back-pressure on beat 2, with a stray start during busy
    run_burst(AW'(32'h20), 3, 1000, 1'b1, 1'b1);
    chk("t3_hold_cycles", 64'(hold_cnt), 64'(10));

    // Timeout on word 1
    run_burst(AW'(32'h100), 2, 1, 1'b0, 1'b0);
    chk("t4_timeout_latency", 64'(done_cyc - last_en_cyc), 64'(TO + 1));
    chk("t4_error_sticky", 64'(error_o), 64'(1));

    // Zero-length burst
    run_burst(AW'(32'h10), 0, 1000, 1'b0, 1'b0);

    // Randomized bursts
    rand_ready = 1'b1;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom();
      b   = AW'($urandom_range(0, 32'h3FFFFF));
      n   = $urandom_range(1, 6);
      sup = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : 1000;
      run_burst(b, n, sup, 1'b0, (r % 3) == 0);
    end

    // Reset while waiting on word 2
    rand_ready = 1'b0;
    @(negedge clk);
    b = AW'(32'h200);
    for (int i = 0; i < 1; i++) begin
      exp_addr_q.push_back(b);
      exp_data_q.push_back(mem[b[9:2]]);
    end
    en_cnt = 0; done_cnt = 0; beats_seen = 0; suppress_idx = 1;
    start_i = 1'b1; base_addr_i = b; num_words_i = CW'(3);
    @(negedge clk);
    start_i = 1'b0;
    begin
      int k;
      k = 0;
      while (en_cnt < 2 && k < 200) begin
        @(negedge clk);
        k++;
      end
    end
    chk("t6_reached_word2", 64'(en_cnt), 64'(2));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_status", 64'({busy_o, done_o, error_o, en_b_o, valid_o}), 64'(0));
    chk("t6_async_data", 64'(data_o), 64'(0));
    chk("t6_async_addrs", 64'({data_addr_o, addr_b_o}), 64'(0));
    repeat (3) begin
      @(negedge clk);
      chk("t6_no_done_in_reset", 64'(done_o), 64'(0));
    end
    exp_addr_q.delete();
    exp_data_q.delete();
    suppress_idx = 1000;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_no_done_after_reset", 64'(done_cnt), 64'(0));
    run_burst(AW'(32'h300), 4, 1000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
